// File: rtl/core_pkg.sv
// Shared definitions for the fetch/decode/sequence stage: ALU function codes,
// instruction class/func encodings, FSM state encoding and the jump condition.
// Optional single-step mode is enabled with CONTROL_UNIT_STEP_EN.
package core_pkg;

    // ALU function codes driven on alu_control
    localparam logic [2:0] ALU_NAND = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SHR  = 3'b011;
    localparam logic [2:0] ALU_MOV  = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b110;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    // Instruction class field [7:6]
    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_JUMP    = 2'b10;
    localparam logic [1:0] CLS_MISC    = 2'b11;

    // Jump func field [5:3]
    localparam logic [2:0] J_JMP = 3'b000;
    localparam logic [2:0] J_JZ  = 3'b001;
    localparam logic [2:0] J_JNZ = 3'b010;
    localparam logic [2:0] J_JC  = 3'b011;
    localparam logic [2:0] J_JNC = 3'b100;

    // Misc func field [5:3]
    localparam logic [2:0] M_NOP  = 3'b000;
    localparam logic [2:0] M_HALT = 3'b001;
    localparam logic [2:0] M_ST   = 3'b010;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_FETCH_IMM = 3'd1,
        S_EXEC      = 3'd2,
        S_WB        = 3'd3,
        S_HALT      = 3'd4
`ifdef CONTROL_UNIT_STEP_EN
        , S_WAIT_STEP = 3'd5
`endif
    } state_e;

    // Branch condition from the flags the ALU currently presents
    function automatic logic jump_taken(input logic [2:0] func,
                                        input logic zf, input logic cf);
        case (func)
            J_JMP:   jump_taken = 1'b1;
            J_JZ:    jump_taken = zf;
            J_JNZ:   jump_taken = ~zf;
            J_JC:    jump_taken = cf;
            J_JNC:   jump_taken = ~cf;
            default: jump_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile4.sv
// 4x8 register file: one write port, async reads of r0 (accumulator) and r[sel].
module regfile4 #(
    parameter int NREGS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] rsel,
    output logic [7:0] r0,
    output logic [7:0] rdata
);

    logic [NREGS-1:0][7:0] regs_q, regs_d;

    // Next-state: single write port
    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    // Storage, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    assign r0    = regs_q[0];
    assign rdata = regs_q[rsel];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/sequence stage feeding the 8-bit ALU.
// Fetches over a req/ack byte port, sequences EXEC/WB, resolves jumps on zf/cf.
// CONTROL_UNIT_STEP_EN adds a 'step' input and a WAIT_STEP state after each
// completed instruction.
module control_unit
    import core_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         NREGS    = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_control,
    output logic       alu_execute,
    input  logic [7:0] alu_out,
    input  logic       alu_zf,
    input  logic       alu_cf,
`ifdef CONTROL_UNIT_STEP_EN
    input  logic       step,
`endif
    output logic       halted
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [2:0] alu_ctl_q, alu_ctl_d;
    logic       req_q, req_d;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [1:0] rf_rsel;
    logic [7:0] r0, rsel_data;
    logic       ack_ok;
    state_e     done_state;

    regfile4 #(.NREGS(NREGS)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .rsel  (rf_rsel),
        .r0    (r0),
        .rdata (rsel_data)
    );

    // An ack only counts while a request is actually outstanding in a fetch state
    assign ack_ok = req_q & mem_ack &
                    ((state_q == S_FETCH) | (state_q == S_FETCH_IMM));

`ifdef CONTROL_UNIT_STEP_EN
    assign done_state = S_WAIT_STEP;
`else
    assign done_state = S_FETCH;
`endif

    // Next-state, datapath updates and register-file write selection
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_b_d   = alu_b_q;
        alu_ctl_d = alu_ctl_q;
        rf_we     = 1'b0;
        rf_waddr  = 2'd0;
        rf_wdata  = r0;
        rf_rsel   = ir_q[1:0];

        case (state_q)
            S_FETCH: begin
                // Decode straight off the bus so r[sel] is captured on the ack
                rf_rsel = mem_data[1:0];
                if (ack_ok) begin
                    ir_d = mem_data;
                    pc_d = pc_q + 8'd1;
                    case (mem_data[7:6])
                        CLS_ALU_REG: begin
                            alu_ctl_d = mem_data[5:3];
                            alu_b_d   = rsel_data;
                            state_d   = S_EXEC;
                        end
                        CLS_ALU_IMM: begin
                            alu_ctl_d = mem_data[5:3];
                            state_d   = S_FETCH_IMM;
                        end
                        CLS_JUMP: state_d = S_FETCH_IMM;
                        default: begin
                            if (mem_data[5:3] == M_HALT) begin
                                state_d = S_HALT;
                            end else begin
                                // ST to r0 would be r0<=r0, so it is skipped
                                if (mem_data[5:3] == M_ST && mem_data[1:0] != 2'd0) begin
                                    rf_we    = 1'b1;
                                    rf_waddr = mem_data[1:0];
                                end
                                state_d = done_state;
                            end
                        end
                    endcase
                end
            end
            S_FETCH_IMM: begin
                if (ack_ok) begin
                    pc_d = pc_q + 8'd1;
                    if (ir_q[7:6] == CLS_ALU_IMM) begin
                        alu_b_d = mem_data;
                        state_d = S_EXEC;
                    end else begin
                        if (jump_taken(ir_q[5:3], alu_zf, alu_cf)) pc_d = mem_data;
                        state_d = done_state;
                    end
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                // CMP only updates the ALU flags
                if (alu_ctl_q != ALU_CMP) begin
                    rf_we    = 1'b1;
                    rf_waddr = 2'd0;
                    rf_wdata = alu_out;
                end
                state_d = done_state;
            end
            S_HALT: state_d = S_HALT;
`ifdef CONTROL_UNIT_STEP_EN
            S_WAIT_STEP: if (step) state_d = S_FETCH;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Request is registered: it drops the cycle after an accepted ack and
    // rises one cycle after entering (or staying in) a fetch state
    always_comb begin
        req_d = ((state_d == S_FETCH) | (state_d == S_FETCH_IMM)) & ~ack_ok;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 8'h00;
            alu_b_q   <= 8'h00;
            alu_ctl_q <= 3'b000;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_b_q   <= alu_b_d;
            alu_ctl_q <= alu_ctl_d;
            req_q     <= req_d;
        end
    end

    logic unused_ir_bit;
    assign unused_ir_bit = ir_q[2];

    assign mem_addr    = pc_q;
    assign mem_req     = req_q;
    assign alu_a       = r0;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctl_q;
    assign alu_execute = (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a behavioural byte memory (programmable
// ack delay) and a registered 8-bit ALU model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_control;
    logic       alu_execute;
    logic [7:0] alu_out;
    logic       alu_zf, alu_cf;
    logic       halted;
`ifdef CONTROL_UNIT_STEP_EN
    logic       step;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_execute(alu_execute),
        .alu_out(alu_out), .alu_zf(alu_zf), .alu_cf(alu_cf),
`ifdef CONTROL_UNIT_STEP_EN
        .step(step),
`endif
        .halted(halted)
    );

    // Memory: ack comes after 'delay' extra cycles of request
    logic [7:0] mem [256];
    int         delay = 0;
    int         wcnt  = 0;
    assign mem_ack  = mem_req && (wcnt == delay);
    assign mem_data = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    // ALU model: result and flags registered on alu_execute
    always @(posedge clk) begin
        if (reset) begin
            alu_out <= 8'h00; alu_zf <= 1'b0; alu_cf <= 1'b0;
        end else if (alu_execute) begin
            logic [8:0] t;
            t = 9'h0;
            case (alu_control)
                3'b000: t = {1'b0, ~(alu_a & alu_b)};
                3'b001: t = {1'b0, alu_a & alu_b};
                3'b010: t = {1'b0, alu_a ^ alu_b};
                3'b011: t = {alu_a[0], 1'b0, alu_a[7:1]};
                3'b100: t = {1'b0, alu_b};
                3'b110: t = {1'b0, alu_a} + {1'b0, alu_b};
                3'b111: t = {1'b0, alu_a} - {1'b0, alu_b};
                default: t = {1'b0, alu_a};
            endcase
            if (alu_control != 3'b111) alu_out <= t[7:0];
            alu_zf <= (t[7:0] == 8'h00);
            alu_cf <= t[8];
        end
    end

    // Monitor: execute pulses, last acked address, request stability while waiting
    int         exec_cnt = 0;
    int         hold_viol = 0;
    logic [7:0] last_ack_addr = 8'h00;
    logic       prev_wait = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    always @(negedge clk) begin
        if (!reset) begin
            if (alu_execute) exec_cnt <= exec_cnt + 1;
            if (mem_req && mem_ack) last_ack_addr <= mem_addr;
            if (prev_wait && (!mem_req || mem_addr != prev_addr)) hold_viol <= hold_viol + 1;
        end
        prev_wait <= !reset && mem_req && !mem_ack;
        prev_addr <= mem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hC8;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_halt_reached"}, halted, 1'b1);
    endtask

    int base;
    int cyc_fast;
    int cyc_slow;
    int n;

    initial begin
        reset = 1'b1;
`ifdef CONTROL_UNIT_STEP_EN
        step = 1'b1;
`endif
        clear_mem();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req", mem_req, 1'b0);
        chk("rst_exec", alu_execute, 1'b0);
        chk("rst_ctl", alu_control, 3'b000);
        chk("rst_halted", halted, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);

        // MOV imm 5 (01_100_000) ; ADD imm 3 ; HALT at 4
        mem[0] = 8'h60; mem[1] = 8'h05; mem[2] = 8'h70; mem[3] = 8'h03; mem[4] = 8'hC8;
        base = exec_cnt;
        reset = 1'b0;
        n = 0;
        while (!halted && n < 400) begin @(negedge clk); n++; end
        cyc_fast = n;
        chk("t1_halt", halted, 1'b1);
        chk("t1_r0", alu_a, 8'd8);
        chk("t1_exec_pulses", exec_cnt - base, 2);
        chk("t1_pc_at_halt", last_ack_addr, 8'h04);
        repeat (6) @(negedge clk);
        chk("t1_no_req_halted", mem_req, 1'b0);

        // MOV 8 ; CMP 8 ; JZ 0x20 -> taken
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'h08; mem[2] = 8'h78; mem[3] = 8'h08;
        mem[4] = 8'h88; mem[5] = 8'h20;
        do_reset();
        wait_halt("t2");
        chk("t2_zf", alu_zf, 1'b1);
        chk("t2_r0", alu_a, 8'd8);
        chk("t2_target", last_ack_addr, 8'h20);

        // MOV 7 ; CMP 8 ; JNC 0x20 -> not taken, halts at 6
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'h07; mem[2] = 8'h78; mem[3] = 8'h08;
        mem[4] = 8'hA0; mem[5] = 8'h20;
        do_reset();
        wait_halt("t3");
        chk("t3_cf", alu_cf, 1'b1);
        chk("t3_r0", alu_a, 8'd7);
        chk("t3_fallthru", last_ack_addr, 8'h06);

        // First program again with 3 wait cycles on every fetch
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'h05; mem[2] = 8'h70; mem[3] = 8'h03; mem[4] = 8'hC8;
        delay = 3;
        do_reset();
        base = exec_cnt;
        n = 0;
        while (!halted && n < 400) begin @(negedge clk); n++; end
        cyc_slow = n;
        chk("t4_halt", halted, 1'b1);
        chk("t4_r0", alu_a, 8'd8);
        chk("t4_exec_pulses", exec_cnt - base, 2);
        chk("t4_pc_at_halt", last_ack_addr, 8'h04);
        chk("t4_req_hold", hold_viol, 0);
        // five fetches each wait three extra cycles
        chk("t4_wait_cycles", cyc_slow - cyc_fast, 15);

        // ST r1 ; reg-class ADD r1: MOV 5 ; ST r1 ; MOV 0 ; ADD r1 -> r0=5
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'h05; mem[2] = 8'hD1; mem[3] = 8'h60; mem[4] = 8'h00;
        mem[5] = 8'h31; mem[6] = 8'hC8;
        delay = 0;
        do_reset();
        base = exec_cnt;
        wait_halt("t5");
        chk("t5_r0", alu_a, 8'd5);
        chk("t5_exec_pulses", exec_cnt - base, 3);
        chk("t5_alu_b_reg", alu_b, 8'd5);

        // JMP 0xFF ; NOP at 0xFF -> next fetch wraps to 0x00
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'hFF; mem[255] = 8'hC0;
        do_reset();
        n = 0;
        while (!(mem_req && mem_ack && mem_addr == 8'hFF) && n < 100) begin @(negedge clk); n++; end
        chk("t6_reach_ff", mem_addr, 8'hFF);
        @(negedge clk);
        n = 0;
        while (!mem_req && n < 100) begin @(negedge clk); n++; end
        chk("t6_wrap_addr", mem_addr, 8'h00);
        chk("t6_not_halted", halted, 1'b0);

        // Reset while waiting on the second byte of a jump
        delay = 3;
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 8'h01) && n < 100) begin @(negedge clk); n++; end
        chk("t7_in_fetch_imm", mem_addr, 8'h01);
        reset = 1'b1;
        @(negedge clk);
        chk("t7_req_dropped", mem_req, 1'b0);
        chk("t7_pc_reset", mem_addr, 8'h00);
        reset = 1'b0;
        n = 0;
        while (!mem_req && n < 100) begin @(negedge clk); n++; end
        chk("t7_refetch_addr", mem_addr, 8'h00);
        delay = 0;

`ifdef CONTROL_UNIT_STEP_EN
        // NOP then HALT, with step held low: stall after the NOP
        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'hC8;
        step = 1'b0;
        do_reset();
        repeat (12) @(negedge clk);
        chk("t8_stalled_req", mem_req, 1'b0);
        chk("t8_stalled_halt", halted, 1'b0);
        chk("t8_stalled_addr", mem_addr, 8'h01);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_halt("t8");
        chk("t8_halt_addr", last_ack_addr, 8'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
